// File: rtl/locker_code_tx.sv
// Serial code transmitter for the digital locker: submit pulse, MSB-first code shift, result report.
// Optional LOCKOUT state after MAX_FAIL consecutive failures is enabled by `define LOCKER_TX_LOCKOUT_EN.
module locker_code_tx #(
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned FAIL_W      = 3,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CODE_W-1:0] code,
    input  logic              unlocked_in,
    output logic              ready,
    output logic              pwd_out,
    output logic              submit,
    output logic              done,
    output logic              granted,
    output logic [FAIL_W-1:0] fail_cnt,
    output logic              lockout
);

    localparam int unsigned FAIL_SAT = (1 << FAIL_W) - 1;
    localparam int unsigned CNT_MAX  = (CODE_W + 1 > LOCKOUT_CYC) ? CODE_W + 1 : LOCKOUT_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    if (MAX_FAIL < 1 || MAX_FAIL > FAIL_SAT) begin : g_bad_max_fail
        $error("locker_code_tx: MAX_FAIL out of range");
    end
    if (LOCKOUT_CYC < 1) begin : g_bad_lockout_cyc
        $error("locker_code_tx: LOCKOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_PARK,
        S_READY,
        S_ARM,
        S_SHIFT,
        S_CHECK
`ifdef LOCKER_TX_LOCKOUT_EN
        , S_LOCKOUT
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CODE_W-1:0]   r_shreg;
    logic [CODE_W-1:0]   w_shreg_nxt;
    logic [FAIL_W-1:0]   r_fail;
    logic [FAIL_W-1:0]   w_fail_nxt;
    logic [FAIL_W-1:0]   w_fail_inc;
    logic                r_ready, w_ready;
    logic                r_pwd, w_pwd;
    logic                r_submit, w_submit;
    logic                r_done, w_done;
    logic                r_granted, w_granted;
    logic                r_lockout, w_lockout;

    // Next state and next registered outputs; one shared counter times PARK, SHIFT and LOCKOUT.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_fail_nxt  = r_fail;
        w_done      = 1'b0;
        w_granted   = 1'b0;
        w_submit    = 1'b0;
        w_pwd       = 1'b0;
        w_lockout   = 1'b0;
        w_fail_inc  = (r_fail == FAIL_W'(FAIL_SAT)) ? r_fail : r_fail + FAIL_W'(1);

        case (r_state)
            S_PARK: begin
                if (r_cnt == CNT_W'(CODE_W)) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (start) begin
                    w_shreg_nxt = code;
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(CODE_W - 1)) w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_done      = 1'b1;
                w_granted   = unlocked_in;
                w_state_nxt = S_READY;
                if (unlocked_in) begin
                    w_fail_nxt = '0;
                end else begin
                    w_fail_nxt = w_fail_inc;
`ifdef LOCKER_TX_LOCKOUT_EN
                    if (w_fail_inc == FAIL_W'(MAX_FAIL)) w_state_nxt = S_LOCKOUT;
`endif
                end
            end
`ifdef LOCKER_TX_LOCKOUT_EN
            S_LOCKOUT: begin
                if (r_cnt == CNT_W'(LOCKOUT_CYC - 1)) begin
                    w_state_nxt = S_READY;
                    w_fail_nxt  = '0;
                end
            end
`endif
            default: w_state_nxt = S_PARK;
        endcase

        // The bit driven during a SHIFT cycle is loaded on the edge that enters that cycle.
        if (w_state_nxt == S_SHIFT) begin
            w_pwd       = r_shreg[CODE_W-1];
            w_shreg_nxt = r_shreg << 1;
        end

        w_submit  = (w_state_nxt == S_ARM);
        w_ready   = (w_state_nxt == S_READY);
`ifdef LOCKER_TX_LOCKOUT_EN
        w_lockout = (w_state_nxt == S_LOCKOUT);
`endif
        w_cnt_nxt = (w_state_nxt != r_state) ? '0 : r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_PARK;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_fail    <= '0;
            r_ready   <= 1'b0;
            r_pwd     <= 1'b0;
            r_submit  <= 1'b0;
            r_done    <= 1'b0;
            r_granted <= 1'b0;
            r_lockout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_fail    <= w_fail_nxt;
            r_ready   <= w_ready;
            r_pwd     <= w_pwd;
            r_submit  <= w_submit;
            r_done    <= w_done;
            r_granted <= w_granted;
            r_lockout <= w_lockout;
        end
    end

    assign ready    = r_ready;
    assign pwd_out  = r_pwd;
    assign submit   = r_submit;
    assign done     = r_done;
    assign granted  = r_granted;
    assign fail_cnt = r_fail;
    assign lockout  = r_lockout;

endmodule

// File: tb/tb_locker_code_tx.sv
// Directed bench for locker_code_tx with a behavioural locker on the serial side.
module tb_locker_code_tx;

    localparam int unsigned CODE_W = 4;
    localparam int unsigned FAIL_W = 3;
`ifdef LOCKER_TX_LOCKOUT_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CODE_W-1:0] code;
    logic              unlocked_in;
    logic              ready, pwd_out, submit, done, granted, lockout;
    logic [FAIL_W-1:0] fail_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    locker_code_tx #(
        .CODE_W(CODE_W), .FAIL_W(FAIL_W), .MAX_FAIL(3), .LOCKOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .code(code), .unlocked_in(unlocked_in),
        .ready(ready), .pwd_out(pwd_out), .submit(submit), .done(done),
        .granted(granted), .fail_cnt(fail_cnt), .lockout(lockout)
    );

    always #5 clk = ~clk;

    // Locker stand-in: submit re-arms, then four bits are shifted in; secret is 4'b1100.
    logic [3:0] m_seq;
    int         m_idx;
    logic       m_unl;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_seq <= '0;
            m_idx <= 4;
            m_unl <= 1'b0;
        end else if (submit) begin
            m_idx <= 0;
            m_unl <= 1'b0;
        end else if (m_idx < 4) begin
            m_seq <= {m_seq[2:0], pwd_out};
            m_idx <= m_idx + 1;
            if (m_idx == 3) m_unl <= ({m_seq[2:0], pwd_out} == 4'b1100);
        end
    end
    assign unlocked_in = m_unl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    // One attempt, cycle 0 at the current (or next) negedge; returns at the negedge of cycle CODE_W+3.
    task automatic attempt(input logic [3:0] c, input bit skip_start, input bit poke,
                           input logic exp_g, input logic [2:0] exp_f,
                           input logic exp_rdy, input logic exp_lk);
        if (!skip_start) begin
            @(negedge clk);
            wait_ready();
            start = 1'b1;
            code  = c;
        end
        @(negedge clk);
        start = 1'b0;
        check("arm_submit", submit, 1);
        check("arm_ready", ready, 0);
        check("arm_pwd", pwd_out, 0);
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            start = poke && (k == 2);
            check("shift_pwd", pwd_out, c[k]);
            check("shift_submit", submit, 0);
            check("shift_ready", ready, 0);
        end
        start = 1'b0;
        @(negedge clk);
        check("check_done", done, 0);
        check("check_pwd", pwd_out, 0);
        @(negedge clk);
        check("res_done", done, 1);
        check("res_granted", granted, exp_g);
        check("res_ready", ready, exp_rdy);
        check("res_fail_cnt", fail_cnt, exp_f);
        check("res_lockout", lockout, exp_lk);
        check("locker_unlocked", m_unl, exp_g);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_pwd"}, pwd_out, 0);
        check({tag, "_submit"}, submit, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_granted"}, granted, 0);
        check({tag, "_fail"}, fail_cnt, 0);
        check({tag, "_lockout"}, lockout, 0);
    endtask

    task automatic park_after_release();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("park_ready", ready, (i == 5) ? 1 : 0);
            if (i == 4) begin
                check("park_submit", submit, 0);
                check("park_done", done, 0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        code  = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        park_after_release();

        attempt(4'b1100, 0, 0, 1, 0, 1, 0);
        attempt(4'b1010, 0, 0, 0, 1, 1, 0);
        attempt(4'b1100, 0, 0, 1, 0, 1, 0);

        // start poked mid-attempt must neither queue nor restart
        attempt(4'b1010, 0, 1, 0, 1, 1, 0);
        @(negedge clk);
        check("busy_done_once", done, 0);
        check("busy_no_submit", submit, 0);
        check("busy_ready", ready, 1);
        attempt(4'b1100, 0, 0, 1, 0, 1, 0);

        // back-to-back: start held in the done cycle
        attempt(4'b0110, 0, 0, 0, 1, 1, 0);
        start = 1'b1;
        code  = 4'b1100;
        attempt(4'b1100, 1, 0, 1, 0, 1, 0);

        attempt(4'b1010, 0, 0, 0, 1, 1, 0);
        attempt(4'b0001, 0, 0, 0, 2, 1, 0);
        attempt(4'b1111, 0, 0, 0, 3, !LK, LK);
        if (LK) begin
            for (int c = 8; c <= 22; c++) begin
                @(negedge clk);
                start = (c == 10);
                check("lk_active", lockout, 1);
                check("lk_ready", ready, 0);
                check("lk_submit", submit, 0);
            end
            start = 1'b0;
            @(negedge clk);
            check("lk_exit_lockout", lockout, 0);
            check("lk_exit_ready", ready, 1);
            check("lk_exit_fail", fail_cnt, 0);
            check("lk_exit_submit", submit, 0);
        end else begin
            attempt(4'b1010, 0, 0, 0, 4, 1, 0);
            attempt(4'b1010, 0, 0, 0, 5, 1, 0);
            attempt(4'b1010, 0, 0, 0, 6, 1, 0);
            attempt(4'b1010, 0, 0, 0, 7, 1, 0);
            attempt(4'b1010, 0, 0, 0, 7, 1, 0);
            attempt(4'b1100, 0, 0, 1, 0, 1, 0);
        end

        // reset in the middle of SHIFT
        attempt(4'b1010, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        wait_ready();
        start = 1'b1;
        code  = 4'b1100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_pwd_before_rst", pwd_out, 1);
        #2 rst = 1'b0;
        #1 check_idle_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        park_after_release();
        attempt(4'b1100, 0, 0, 1, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
